// File: rtl/led_pulse_monitor_pkg.sv
// led_pulse_monitor_pkg: shared states, status bit positions and defaults for the LED pulse monitor
package led_pulse_monitor_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE, S_DONE} state_t;
  localparam int ST_BUSY = 0;
  localparam int ST_NO_PPS = 1;
  localparam int ST_NO_FLAG = 2;
  localparam int ST_SAT = 3;
  localparam int DEF_DELAY_WIDTH = 27;
  localparam int DEF_WIDTH_WIDTH = 16;
  localparam int DEF_FLAG_TIMEOUT = 255;
  // slow-control address of the packed status words
  localparam logic [7:0] LED_MON_REG_ADDR = 8'h40;
endpackage

// File: rtl/synchronizer_1bit.sv
// synchronizer_1bit: two-flop synchronizer for a single asynchronous bit
module synchronizer_1bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q <= 1'b0;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/led_pulse_monitor.sv
// led_pulse_monitor: measures PPS->LED delay, LED width, LED->flag offset and flag width
module led_pulse_monitor
  import led_pulse_monitor_pkg::*;
#(
  parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
  parameter int WIDTH_WIDTH = DEF_WIDTH_WIDTH,
  parameter int FLAG_TIMEOUT = DEF_FLAG_TIMEOUT
) (
  input  logic                   CLK120,
  input  logic                   RESET_N,
  input  logic                   ONE_PPS,
  input  logic                   LED,
  input  logic                   TRG_FLAG,
  input  logic                   ARM,
  output logic [DELAY_WIDTH-1:0] LED_DELAY,
  output logic [WIDTH_WIDTH-1:0] LED_WIDTH,
  output logic [WIDTH_WIDTH-1:0] FLAG_OFFSET,
  output logic [WIDTH_WIDTH-1:0] FLAG_WIDTH,
  output logic [15:0]            EVENT_COUNT,
  output logic                   VALID,
  output logic [3:0]             STATUS
);
  localparam logic [DELAY_WIDTH-1:0] D_MAX = '1;
  localparam logic [DELAY_WIDTH-1:0] D_ONE = 1;
  localparam logic [WIDTH_WIDTH-1:0] W_MAX = '1;
  localparam logic [WIDTH_WIDTH-1:0] W_ONE = 1;
  localparam logic [WIDTH_WIDTH-1:0] TIMEOUT = WIDTH_WIDTH'(FLAG_TIMEOUT);
  state_t state, state_nxt;
  logic pps_sync, pps_prev, led_prev, flag_prev, arm_prev, pps_seen;
  logic pps_edge, led_rise, flag_rise, arm_rise;
  logic arm, capture, finish;
  logic led_done, flag_done, flag_active;
  logic [DELAY_WIDTH-1:0] pps_cnt;
  logic [WIDTH_WIDTH-1:0] led_cnt, off_cnt, flag_cnt;
  synchronizer_1bit u_pps_sync (
    .clk(CLK120),
    .rst_n(RESET_N),
    .d(ONE_PPS),
    .q(pps_sync)
  );
  assign pps_edge = pps_sync & ~pps_prev;
  assign led_rise = LED & ~led_prev;
  assign flag_rise = TRG_FLAG & ~flag_prev;
  assign arm_rise = ARM & ~arm_prev;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = arm_rise ? S_ARMED : state;
      S_ARMED: state_nxt = led_rise ? S_MEASURE : state;
      S_MEASURE: state_nxt = (led_done && flag_done) ? S_DONE : state;
      default: state_nxt = S_IDLE;
    endcase
    arm = ((state == S_IDLE) || (state == S_DONE)) && arm_rise;
    capture = (state == S_ARMED) && led_rise;
    finish = (state == S_MEASURE) && led_done && flag_done;
  end
  always_ff @(posedge CLK120) begin
    if (!RESET_N) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge CLK120) begin
    if (!RESET_N) begin
      pps_prev <= 1'b0;
      led_prev <= 1'b0;
      flag_prev <= 1'b0;
      arm_prev <= 1'b0;
      pps_seen <= 1'b0;
      pps_cnt <= '0;
    end else begin
      pps_prev <= pps_sync;
      led_prev <= LED;
      flag_prev <= TRG_FLAG;
      arm_prev <= ARM;
      if (pps_edge) begin
        pps_cnt <= '0;
        pps_seen <= 1'b1;
      end else if (pps_cnt != D_MAX) begin
        pps_cnt <= pps_cnt + D_ONE;
      end
    end
  end
  always_ff @(posedge CLK120) begin
    if (!RESET_N) begin
      LED_DELAY <= '0;
      LED_WIDTH <= '0;
      FLAG_OFFSET <= '0;
      FLAG_WIDTH <= '0;
      EVENT_COUNT <= '0;
      VALID <= 1'b0;
      STATUS <= '0;
      led_cnt <= '0;
      off_cnt <= '0;
      flag_cnt <= '0;
      led_done <= 1'b0;
      flag_done <= 1'b0;
      flag_active <= 1'b0;
    end else begin
      STATUS[ST_BUSY] <= (state_nxt == S_ARMED) || (state_nxt == S_MEASURE);
      if (arm) begin
        VALID <= 1'b0;
        STATUS[3:1] <= '0;
      end
      // off_cnt is loaded one ahead so it equals cycles since the LED rise
      if (capture) begin
        LED_DELAY <= pps_seen ? pps_cnt : D_MAX;
        STATUS[ST_NO_PPS] <= ~pps_seen;
        if (pps_seen && (pps_cnt == D_MAX)) STATUS[ST_SAT] <= 1'b1;
        led_cnt <= W_ONE;
        off_cnt <= W_ONE;
        flag_cnt <= W_ONE;
        led_done <= 1'b0;
        flag_done <= 1'b0;
        flag_active <= flag_rise;
        if (flag_rise) FLAG_OFFSET <= '0;
      end
      if (state == S_MEASURE) begin
        if (!led_done) begin
          if (LED) begin
            if (led_cnt != W_MAX) led_cnt <= led_cnt + W_ONE;
            if (led_cnt >= W_MAX - W_ONE) STATUS[ST_SAT] <= 1'b1;
          end else begin
            LED_WIDTH <= led_cnt;
            led_done <= 1'b1;
          end
        end
        if (!flag_done) begin
          if (flag_active) begin
            if (TRG_FLAG) begin
              if (flag_cnt != W_MAX) flag_cnt <= flag_cnt + W_ONE;
              if (flag_cnt >= W_MAX - W_ONE) STATUS[ST_SAT] <= 1'b1;
            end else begin
              FLAG_WIDTH <= flag_cnt;
              flag_done <= 1'b1;
              flag_active <= 1'b0;
            end
          end else if (flag_rise) begin
            FLAG_OFFSET <= off_cnt;
            flag_cnt <= W_ONE;
            flag_active <= 1'b1;
          end else if (off_cnt >= TIMEOUT) begin
            STATUS[ST_NO_FLAG] <= 1'b1;
            flag_done <= 1'b1;
            FLAG_OFFSET <= '0;
            FLAG_WIDTH <= '0;
          end else begin
            off_cnt <= off_cnt + W_ONE;
          end
        end
      end
      if (finish) begin
        VALID <= 1'b1;
        EVENT_COUNT <= EVENT_COUNT + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_led_pulse_monitor.sv
// tb_led_pulse_monitor: directed table-driven bench for led_pulse_monitor
module tb_led_pulse_monitor;
  localparam int PPS_LAT = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic one_pps = 1'b0;
  logic led = 1'b0;
  logic trg_flag = 1'b0;
  logic arm = 1'b0;
  logic [26:0] led_delay;
  logic [15:0] led_width, flag_offset, flag_width, event_count;
  logic valid;
  logic [3:0] status;
  int checks = 0;
  int failures = 0;
  int exp_ev = 0;

  led_pulse_monitor dut (
    .CLK120(clk),
    .RESET_N(rst_n),
    .ONE_PPS(one_pps),
    .LED(led),
    .TRG_FLAG(trg_flag),
    .ARM(arm),
    .LED_DELAY(led_delay),
    .LED_WIDTH(led_width),
    .FLAG_OFFSET(flag_offset),
    .FLAG_WIDTH(flag_width),
    .EVENT_COUNT(event_count),
    .VALID(valid),
    .STATUS(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit do_pps;
    int dly;
    int lw;
    int fo;
    int fw;
    logic [26:0] e_delay;
    logic [15:0] e_width;
    logic [15:0] e_off;
    logic [15:0] e_fw;
    logic [3:0] e_status;
  } vec_t;
  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
  endtask

  task automatic drive(input bit do_pps, input int dly, input int lw, input int fo, input int fw);
    int n;
    n = dly + ((lw > fo + fw) ? lw : fo + fw);
    n = (n > dly + 260) ? n + 4 : dly + 264;
    for (int c = 0; c < n; c++) begin
      one_pps = do_pps && (c < 20);
      led = (c >= dly) && (c < dly + lw);
      trg_flag = (fw > 0) && (c >= dly + fo) && (c < dly + fo + fw);
      tick();
    end
    one_pps = 1'b0;
    led = 1'b0;
    trg_flag = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!valid && k < 50) begin
      tick();
      k++;
    end
    chk(name, {31'd0, valid}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 50, 10, 3, 4, 27'h7ffffff, 16'd10, 16'd3, 16'd4, 4'b0010};
    vecs[1] = '{1'b1, 1000, 10, 40, 5, 27'(1000 - PPS_LAT), 16'd10, 16'd40, 16'd5, 4'b0000};
    vecs[2] = '{1'b1, 200, 1, 0, 1, 27'(200 - PPS_LAT), 16'd1, 16'd0, 16'd1, 4'b0000};
    vecs[3] = '{1'b1, 30, 20, 0, 0, 27'(30 - PPS_LAT), 16'd20, 16'd0, 16'd0, 4'b0100};
    vecs[4] = '{1'b1, 5, 300, 254, 2, 27'(5 - PPS_LAT), 16'd300, 16'd254, 16'd2, 4'b0000};
    vecs[5] = '{1'b1, 100, 3, 255, 1, 27'(100 - PPS_LAT), 16'd3, 16'd255, 16'd1, 4'b0000};
    vecs[6] = '{1'b1, 100, 3, 256, 2, 27'(100 - PPS_LAT), 16'd3, 16'd0, 16'd0, 4'b0100};
    repeat (3) tick();
    chk("reset_delay", {5'd0, led_delay}, 32'd0);
    chk("reset_words", {led_width, flag_offset}, 32'd0);
    chk("reset_fwidth_events", {flag_width, event_count}, 32'd0);
    chk("reset_valid_status", {27'd0, valid, status}, 32'd0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      do_arm();
      chk($sformatf("v%0d_busy", i), {28'd0, status}, 32'd1);
      drive(vecs[i].do_pps, vecs[i].dly, vecs[i].lw, vecs[i].fo, vecs[i].fw);
      wait_valid($sformatf("v%0d_valid", i));
      exp_ev++;
      chk($sformatf("v%0d_delay", i), {5'd0, led_delay}, {5'd0, vecs[i].e_delay});
      chk($sformatf("v%0d_width", i), {16'd0, led_width}, {16'd0, vecs[i].e_width});
      chk($sformatf("v%0d_offset", i), {16'd0, flag_offset}, {16'd0, vecs[i].e_off});
      chk($sformatf("v%0d_fwidth", i), {16'd0, flag_width}, {16'd0, vecs[i].e_fw});
      chk($sformatf("v%0d_status", i), {28'd0, status}, {28'd0, vecs[i].e_status});
      chk($sformatf("v%0d_events", i), {16'd0, event_count}, exp_ev);
    end
    // re-arm clears VALID and error bits but keeps the last results
    do_arm();
    chk("rearm_valid", {31'd0, valid}, 32'd0);
    chk("rearm_status", {28'd0, status}, 32'd1);
    chk("rearm_keep_width", {16'd0, led_width}, 32'd3);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    chk("arm_in_armed", {28'd0, status}, 32'd1);
    for (int c = 0; c < 70030; c++) begin
      one_pps = (c < 20);
      led = (c >= 10) && (c < 70010);
      trg_flag = (c >= 20) && (c < 25);
      if (c == 40000) chk("sat_busy_mid", {27'd0, valid, status}, 32'd1);
      tick();
    end
    led = 1'b0;
    trg_flag = 1'b0;
    wait_valid("sat_valid");
    exp_ev++;
    chk("sat_width", {16'd0, led_width}, 32'd65535);
    chk("sat_status", {28'd0, status}, 32'd8);
    chk("sat_delay", {5'd0, led_delay}, 32'(10 - PPS_LAT));
    chk("sat_flag", {flag_offset, flag_width}, {16'd10, 16'd5});
    chk("sat_events", {16'd0, event_count}, exp_ev);
    do_arm();
    led = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mreset_delay", {5'd0, led_delay}, 32'd0);
    chk("mreset_words", {led_width, flag_offset}, 32'd0);
    chk("mreset_fwidth_events", {flag_width, event_count}, 32'd0);
    chk("mreset_valid_status", {27'd0, valid, status}, 32'd0);
    led = 1'b0;
    repeat (3) tick();
    drive(1'b1, 10, 5, 1, 3);
    chk("noarm_valid_status", {27'd0, valid, status}, 32'd0);
    chk("noarm_width_events", {led_width, event_count}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
